mem_bus_sequencer: RTL and testbench

- Multi-cycle sequencer for the MEM stage. It owns the shared RAM1 data bus and the UART that sits on that bus.
- It accepts one load or store from EX/MEM and decodes the address: RAM1, UART data or UART status.
- It drives RAM1 and UART strobes in the correct phase order and holds `stall` high so the pipeline freezes until the access completes.
- It replaces single-cycle direct strobe generation for data memory.

---
 rtl/mem_bus_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_bus_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_sequencer.sv
// -----------------------------------------------------------------------------
// mem_bus_sequencer
//
// Multi-cycle MEM-stage sequencer that owns the shared RAM1 data bus and the
// UART hanging off it. One load or store is accepted from EX/MEM, its address
// is decoded (RAM1, UART data, UART status) and the matching strobe sequence is
// played out while `stall` freezes the pipeline. `done` pulses for one cycle
// when the access finishes; load results stay on `rdata` until the next load.
//
// Ports
//   CLK, RST           clock; synchronous active-low reset
//   req_read/req_write load / store request levels (store wins if both high)
//   address, wdata     access address and store data (latched on acceptance)
//   rdata, done, stall load result, completion pulse, pipeline freeze
//   ram1EN/OE/WE       RAM1 chip/output/write enables, active-low
//   ram1Addr           RAM1 address = {2'b00, latched address}
//   ram1Data           shared RAM1/UART bus, driven only during store phases
//   data_ready         UART has a received byte
//   tbre, tsre         UART transmit buffer / shift register empty
//   rdn, wrn           UART read / write strobes, active-low
// -----------------------------------------------------------------------------
module mem_bus_sequencer #(
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01,
  parameter int unsigned RAM_WAIT       = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [15:0]       address,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              done,
  output logic              stall,
  output logic              ram1EN,
  output logic              ram1OE,
  output logic              ram1WE,
  output logic [17:0]       ram1Addr,
  inout  wire logic [15:0]  ram1Data,
  input  logic              data_ready,
  input  logic              tbre,
  input  logic              tsre,
  output logic              rdn,
  output logic              wrn
);

  // Counter holds RAM_WAIT-1 down to 0, so it needs clog2(RAM_WAIT) bits.
  localparam int unsigned CW = (RAM_WAIT > 1) ? $clog2(RAM_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_RELOAD = CW'(RAM_WAIT - 1);

  typedef enum logic [3:0] {
    IDLE,
    RR,
    RW_SETUP,
    RW_PULSE,
    RW_HOLD,
    UR_WAIT,
    UR_PULSE,
    UR_CAPT,
    UW_SETUP,
    UW_PULSE,
    UW_TBRE,
    UW_TSRE,
    STAT,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     addr_q;
  logic [15:0]     wdata_q;
  logic            bus_drive;
  logic            req;

  assign req = req_read | req_write;

  // The pipeline must freeze in the very cycle the request is presented,
  // otherwise EX/MEM would advance before the access is latched.
  assign stall    = ((state_q != IDLE) && (state_q != DONE)) ||
                    ((state_q == IDLE) && req);
  assign ram1Addr = {2'b00, addr_q};
  assign ram1Data = bus_drive ? wdata_q : 16'hzzzz;

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;

      if ((state_q == IDLE) && req) begin
        addr_q  <= address;
        wdata_q <= wdata;
      end

      // rdata moves only when a load completes; stores never touch it.
      case (state_q)
        RR:      if (cnt_q == '0) rdata <= ram1Data;
        UR_CAPT: rdata <= {8'h00, ram1Data[7:0]};
        STAT:    rdata <= {14'b0, data_ready, tbre & tsre};
        default: ;
      endcase
    end
  end

  // All strobes are decoded from the current state alone, so a reset edge
  // returns every strobe to inactive in the same cycle the state goes IDLE.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    ram1EN    = 1'b1;
    ram1OE    = 1'b1;
    ram1WE    = 1'b1;
    rdn       = 1'b1;
    wrn       = 1'b1;
    done      = 1'b0;
    bus_drive = 1'b0;

    case (state_q)
      IDLE: begin
        // Store wins when both request lines are high.
        if (req_write) begin
          if (address == UART_DATA_ADDR)      state_d = UW_SETUP;
          else if (address == UART_STAT_ADDR) state_d = DONE;
          else                                state_d = RW_SETUP;
        end else if (req_read) begin
          if (address == UART_DATA_ADDR) begin
            state_d = UR_WAIT;
          end else if (address == UART_STAT_ADDR) begin
            state_d = STAT;
          end else begin
            state_d = RR;
            cnt_d   = WAIT_RELOAD;
          end
        end
      end

      RR: begin
        ram1EN = 1'b0;
        ram1OE = 1'b0;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end

      RW_SETUP: begin
        ram1EN    = 1'b0;
        bus_drive = 1'b1;
        state_d   = RW_PULSE;
        cnt_d     = WAIT_RELOAD;
      end

      RW_PULSE: begin
        ram1EN    = 1'b0;
        ram1WE    = 1'b0;
        bus_drive = 1'b1;
        if (cnt_q == '0) state_d = RW_HOLD;
        else             cnt_d   = cnt_q - 1'b1;
      end

      // Data stays on the bus one cycle past the WE rising edge for hold time.
      RW_HOLD: begin
        ram1EN    = 1'b0;
        bus_drive = 1'b1;
        state_d   = DONE;
      end

      UR_WAIT: begin
        if (data_ready) state_d = UR_PULSE;
      end

      UR_PULSE: begin
        rdn     = 1'b0;
        state_d = UR_CAPT;
      end

      // rdn is still low here, so the UART is driving the captured byte.
      UR_CAPT: begin
        rdn     = 1'b0;
        state_d = DONE;
      end

      UW_SETUP: begin
        bus_drive = 1'b1;
        state_d   = UW_PULSE;
      end

      UW_PULSE: begin
        wrn       = 1'b0;
        bus_drive = 1'b1;
        state_d   = UW_TBRE;
      end

      UW_TBRE: begin
        if (tbre) state_d = UW_TSRE;
      end

      UW_TSRE: begin
        if (tsre) state_d = DONE;
      end

      STAT: begin
        state_d = DONE;
      end

      // A request seen here waits for IDLE; stall is low so the pipeline
      // advances and presents its next instruction first.
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_sequencer.sv
module tb_mem_bus_sequencer;

  localparam int          W     = 1;
  localparam logic [15:0] UDATA = 16'hBF00;
  localparam logic [15:0] USTAT = 16'hBF01;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_read, req_write;
  logic [15:0] address, wdata;
  logic [15:0] rdata;
  logic        done, stall;
  logic        ram1EN, ram1OE, ram1WE;
  logic [17:0] ram1Addr;
  wire  [15:0] ram1Data;
  logic        data_ready, tbre, tsre;
  logic        rdn, wrn;

  mem_bus_sequencer #(
    .UART_DATA_ADDR(UDATA),
    .UART_STAT_ADDR(USTAT),
    .RAM_WAIT      (W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_read  (req_read),
    .req_write (req_write),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata),
    .done      (done),
    .stall     (stall),
    .ram1EN    (ram1EN),
    .ram1OE    (ram1OE),
    .ram1WE    (ram1WE),
    .ram1Addr  (ram1Addr),
    .ram1Data  (ram1Data),
    .data_ready(data_ready),
    .tbre      (tbre),
    .tsre      (tsre),
    .rdn       (rdn),
    .wrn       (wrn)
  );

  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------- devices
  function automatic logic [15:0] init_val(input logic [9:0] i);
    return {6'b110000, i};
  endfunction

  logic [15:0] dev_mem [0:1023];
  logic        dev_init = 1'b0;
  logic [15:0] uart_rx;
  logic        tb_drv;
  logic [15:0] tb_val;

  always_comb begin
    tb_drv = 1'b0;
    tb_val = '0;
    if (!rdn) begin
      tb_drv = 1'b1;
      tb_val = uart_rx;
    end else if (!ram1EN && !ram1OE) begin
      tb_drv = 1'b1;
      tb_val = dev_mem[ram1Addr[9:0]];
    end
  end

  assign ram1Data = tb_drv ? tb_val : 16'hzzzz;

  always @(posedge CLK) begin
    if (!dev_init) begin
      for (int i = 0; i < 1024; i++) dev_mem[i] <= init_val(10'(i));
      dev_init <= 1'b1;
    end else if (!ram1EN && !ram1WE) begin
      dev_mem[ram1Addr[9:0]] <= ram1Data;
    end
  end

  // ---------------------------------------------------------------- model
  typedef enum logic [2:0] {K_RR, K_RW, K_UR, K_UW, K_ST, K_STW} kind_t;

  typedef struct {
    bit          wr;
    bit          both;
    bit          hold;
    logic [15:0] address;
    logic [15:0] wdata;
    logic [15:0] rx;
    int          dr_at;
    int          tbre_at;
    int          tsre_at;
    int          exp_len;
    logic [15:0] exp_rdata;
  } txn_t;

  int          passed;
  int          total;
  logic [15:0] cur_rdata;
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] ram_pool [11] = '{16'h0040, 16'h0041, 16'h0042, 16'h0043,
                                 16'h0044, 16'h0045, 16'h0046, 16'h0047,
                                 16'hBF02, 16'hBEFF, 16'h0000};

  function automatic txn_t mk(input bit wr, input bit both, input bit hold,
                              input logic [15:0] a, input logic [15:0] wd,
                              input logic [15:0] rx, input int dr, input int tb,
                              input int ts, input int len, input logic [15:0] rd);
    txn_t t;
    t.wr = wr; t.both = both; t.hold = hold;
    t.address = a; t.wdata = wd; t.rx = rx;
    t.dr_at = dr; t.tbre_at = tb; t.tsre_at = ts;
    t.exp_len = len; t.exp_rdata = rd;
    return t;
  endfunction

  function automatic kind_t kind_of(input txn_t t);
    if (t.address == UDATA) return t.wr ? K_UW : K_UR;
    if (t.address == USTAT) return t.wr ? K_STW : K_ST;
    return t.wr ? K_RW : K_RR;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Cycles from the request cycle (0) to the done cycle.
  function automatic int model_len(input txn_t t);
    int tb_exit;
    case (kind_of(t))
      K_RR:    return W + 1;
      K_RW:    return W + 3;
      K_ST:    return 2;
      K_STW:   return 1;
      K_UR:    return imax(1, t.dr_at) + 3;
      default: begin
        tb_exit = imax(3, t.tbre_at);
        return imax(tb_exit + 1, t.tsre_at) + 1;
      end
    endcase
  endfunction

  function automatic logic [15:0] model_rdata(input txn_t t);
    case (kind_of(t))
      K_RR:    return ref_mem.exists(t.address) ? ref_mem[t.address] : init_val(t.address[9:0]);
      K_UR:    return {8'h00, t.rx[7:0]};
      K_ST:    return {14'b0, t.dr_at <= 1, (t.tbre_at <= 1) && (t.tsre_at <= 1)};
      default: return cur_rdata;
    endcase
  endfunction

  // {stall, done, ram1EN, ram1OE, ram1WE, rdn, wrn, bus_driven} at cycle k.
  function automatic logic [7:0] exp_at(input kind_t kd, input int k, input int n);
    logic st, dn, en, oe, we, rd, wr, drv;
    st = (k < n); dn = (k == n);
    en = 1'b1; oe = 1'b1; we = 1'b1; rd = 1'b1; wr = 1'b1; drv = 1'b0;
    case (kd)
      K_RR: if (k >= 1 && k <= W) begin en = 1'b0; oe = 1'b0; end
      K_RW: begin
        if (k >= 1 && k <= W + 2) begin en = 1'b0; drv = 1'b1; end
        if (k >= 2 && k <= W + 1) we = 1'b0;
      end
      K_UR: if (k == n - 2 || k == n - 1) rd = 1'b0;
      K_UW: begin
        if (k == 1 || k == 2) drv = 1'b1;
        if (k == 2) wr = 1'b0;
      end
      default: ;
    endcase
    return {st, dn, en, oe, we, rd, wr, drv};
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int   kd;
    kd = $urandom_range(0, 5);
    t.wr = (kd % 2) == 1;
    t.both = t.wr && ($urandom_range(0, 1) == 1);
    t.hold = 1'b0;
    case (kd / 2)
      0:       t.address = ram_pool[$urandom_range(0, 10)];
      1:       t.address = UDATA;
      default: t.address = USTAT;
    endcase
    t.wdata = 16'($urandom);
    t.rx = 16'($urandom);
    t.dr_at = $urandom_range(0, 6);
    t.tbre_at = $urandom_range(0, 8);
    t.tsre_at = $urandom_range(0, 10);
    t.exp_len = model_len(t);
    t.exp_rdata = model_rdata(t);
    return t;
  endfunction

  // ---------------------------------------------------------------- checking
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic run_txn(input txn_t t, input string tag);
    kind_t      kd;
    logic [7:0] e;
    kd = kind_of(t);
    for (int k = 0; k <= t.exp_len; k++) begin
      if (k == 0) begin
        req_write = t.wr;
        req_read  = !t.wr || t.both;
        address   = t.address;
        wdata     = t.wdata;
      end else if (!t.hold) begin
        req_write = 1'b0;
        req_read  = 1'b0;
        address   = 16'($urandom);
        wdata     = 16'($urandom);
      end
      uart_rx    = t.rx;
      data_ready = (k >= t.dr_at);
      tbre       = (k >= t.tbre_at);
      tsre       = (k >= t.tsre_at);
      @(negedge CLK);
      e = exp_at(kd, k, t.exp_len);
      check($sformatf("%s k%0d strobes{stall,done,EN,OE,WE,rdn,wrn}", tag, k),
            32'({stall, done, ram1EN, ram1OE, ram1WE, rdn, wrn}), 32'(e[7:1]));
      if (e[0]) check($sformatf("%s k%0d bus", tag, k), 32'(ram1Data), 32'(t.wdata));
      if (k >= 1) check($sformatf("%s k%0d ram1Addr", tag, k), 32'(ram1Addr), 32'({2'b00, t.address}));
      check($sformatf("%s k%0d rdata", tag, k), 32'(rdata),
            32'((k == t.exp_len) ? t.exp_rdata : cur_rdata));
      @(posedge CLK); #1;
    end
    cur_rdata = t.exp_rdata;
    if (kd == K_RW) ref_mem[t.address] = t.wdata;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      req_read  = 1'b0;
      req_write = 1'b0;
      address   = 16'($urandom);
      wdata     = 16'($urandom);
      @(negedge CLK);
      check("idle strobes", 32'({stall, done, ram1EN, ram1OE, ram1WE, rdn, wrn}), 32'(7'b0011111));
      check("idle rdata", 32'(rdata), 32'(cur_rdata));
      @(posedge CLK); #1;
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    txn_t tbl [13];
    txn_t t;
    passed = 0;
    total = 0;
    cur_rdata = '0;

    //            wr both hold addr      wdata     rx        dr  tbre tsre len rdata
    tbl[0]  = mk(0, 0, 0, 16'h0040, 16'h0000, 16'h0000, 99, 99, 99, 2, 16'hC040);
    tbl[1]  = mk(1, 0, 0, 16'h0040, 16'h1234, 16'h0000, 99, 99, 99, 4, 16'hC040);
    tbl[2]  = mk(0, 0, 0, 16'h0040, 16'h0000, 16'h0000, 99, 99, 99, 2, 16'h1234);
    tbl[3]  = mk(0, 0, 0, 16'hBF00, 16'h0000, 16'h0041,  6, 99, 99, 9, 16'h0041);
    tbl[4]  = mk(1, 0, 0, 16'hBF00, 16'h0058, 16'h0000, 99,  5,  7, 8, 16'h0041);
    tbl[5]  = mk(0, 0, 0, 16'hBF01, 16'h0000, 16'h0000,  0,  0, 99, 2, 16'h0002);
    tbl[6]  = mk(1, 0, 0, 16'hBF01, 16'hFFFF, 16'h0000,  0,  0,  0, 1, 16'h0002);
    tbl[7]  = mk(1, 1, 0, 16'h0045, 16'hBEEF, 16'h0000, 99, 99, 99, 4, 16'h0002);
    tbl[8]  = mk(0, 0, 0, 16'hBF02, 16'h0000, 16'h0000, 99, 99, 99, 2, 16'hC302);
    tbl[9]  = mk(0, 0, 0, 16'hBF00, 16'h0000, 16'hA5C3,  0, 99, 99, 4, 16'h00C3);
    tbl[10] = mk(0, 0, 1, 16'h0045, 16'h0000, 16'h0000, 99, 99, 99, 2, 16'hBEEF);
    tbl[11] = mk(0, 0, 0, 16'h0045, 16'h0000, 16'h0000, 99, 99, 99, 2, 16'hBEEF);
    tbl[12] = mk(0, 0, 0, 16'hBF01, 16'h0000, 16'h0000, 99,  0,  0, 2, 16'h0001);

    // Reset with a load already pending.
    RST = 1'b0;
    req_read = 1'b1;
    req_write = 1'b0;
    address = 16'h0040;
    wdata = 16'h0000;
    data_ready = 1'b0;
    tbre = 1'b0;
    tsre = 1'b0;
    uart_rx = 16'h0000;
    @(posedge CLK); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      check($sformatf("reset%0d strobes", i),
            32'({stall, done, ram1EN, ram1OE, ram1WE, rdn, wrn}), 32'(7'b1011111));
      check($sformatf("reset%0d rdata", i), 32'(rdata), 32'h0);
      check($sformatf("reset%0d ram1Addr", i), 32'(ram1Addr), 32'h0);
      @(posedge CLK); #1;
    end
    RST = 1'b1;

    for (int i = 0; i < 13; i++) run_txn(tbl[i], $sformatf("vec%0d", i));
    idle_cycles(2);

    // Reset during the RAM write pulse aborts on that edge.
    req_write = 1'b1;
    req_read = 1'b0;
    address = 16'h0100;
    wdata = 16'h7777;
    @(negedge CLK);
    check("abort req stall", 32'(stall), 32'h1);
    @(posedge CLK); #1;
    req_write = 1'b0;
    address = 16'h0000;
    wdata = 16'h0000;
    @(negedge CLK);
    check("abort setup strobes", 32'({stall, done, ram1EN, ram1OE, ram1WE, rdn, wrn}), 32'(7'b1001111));
    check("abort setup bus", 32'(ram1Data), 32'h7777);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("abort pulse strobes", 32'({stall, done, ram1EN, ram1OE, ram1WE, rdn, wrn}), 32'(7'b1001011));
    RST = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("abort after strobes", 32'({stall, done, ram1EN, ram1OE, ram1WE, rdn, wrn}), 32'(7'b0011111));
    check("abort after rdata", 32'(rdata), 32'h0);
    check("abort after ram1Addr", 32'(ram1Addr), 32'h0);
    RST = 1'b1;
    cur_rdata = '0;
    @(posedge CLK); #1;

    for (int i = 0; i < 150; i++) begin
      idle_cycles($urandom_range(0, 2));
      t = rand_txn();
      run_txn(t, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
